// File: rtl/uart_prog_loader.sv
// UART 8N1 receiver and instruction-memory program loader.
// Bytes are packed MSB-first into 32-bit words and written to ascending
// word addresses until the terminator word arrives or memory is full.
// The core is held in reset until loading has completed.
module uart_prog_loader #(
  parameter int unsigned CLKS_PER_BIT = 87,
  parameter int unsigned ADDR_W       = 14,
  parameter logic [31:0] TERM_WORD    = 32'h00000FFF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              rx_i,
  input  logic              en_i,
  output logic              ready_o,
  output logic              we_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [31:0]       wdata_o,
  output logic              done_o,
  output logic              frame_err_o,
  output logic              core_rst_no
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] MID  = CNT_W'(CLKS_PER_BIT / 2);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic [2:0]         idx, idx_nx;
  logic [7:0]         shift, shift_nx;
  logic               hold, hold_nx;
  logic               byte_valid, frame_set;
  logic               rx_meta, rx_s;

  logic [23:0]        partial;
  logic [1:0]         bcnt;
  logic               we, done, ready, frame;
  logic [ADDR_W-1:0]  addr;
  logic [31:0]        wdata;
  logic [31:0]        word_full;

  assign word_full = {partial, shift};

  // Two-flop synchroniser for the asynchronous serial line (idles high).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
    end
  end

  // Byte receiver state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
      hold  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      idx   <= idx_nx;
      shift <= shift_nx;
      hold  <= hold_nx;
    end
  end

  // Byte receiver next state: mid-start confirm, mid-bit sampling, stop check.
  // hold marks a framing error: stay in STOP until the line returns high.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    idx_nx     = idx;
    shift_nx   = shift;
    hold_nx    = hold;
    byte_valid = 1'b0;
    frame_set  = 1'b0;
    if (!en_i || done) begin
      state_nx = IDLE;
      cnt_nx   = '0;
      idx_nx   = '0;
      hold_nx  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state_nx = START;
            cnt_nx   = '0;
          end
        end
        START: begin
          if (cnt == MID) begin
            cnt_nx   = '0;
            idx_nx   = '0;
            state_nx = rx_s ? IDLE : DATA;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == LAST) begin
            cnt_nx        = '0;
            shift_nx[idx] = rx_s;
            if (idx == 3'd7) state_nx = STOP;
            else             idx_nx   = idx + 1'b1;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        STOP: begin
          if (hold) begin
            if (rx_s) begin
              hold_nx  = 1'b0;
              cnt_nx   = '0;
              state_nx = IDLE;
            end
          end else if (cnt == LAST) begin
            cnt_nx = '0;
            if (rx_s) begin
              byte_valid = 1'b1;
              state_nx   = IDLE;
            end else begin
              frame_set = 1'b1;
              hold_nx   = 1'b1;
            end
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Word assembly, memory write strobe, address advance and sticky flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      partial <= '0;
      bcnt    <= '0;
      we      <= 1'b0;
      addr    <= '0;
      wdata   <= '0;
      done    <= 1'b0;
      ready   <= 1'b0;
      frame   <= 1'b0;
    end else begin
      we    <= 1'b0;
      ready <= en_i & ~done;
      if (frame_set) frame <= 1'b1;
      if (we) begin
        if (addr == '1) done <= 1'b1;
        else            addr <= addr + 1'b1;
      end
      if (!en_i || done) begin
        bcnt <= '0;
      end else if (byte_valid) begin
        partial <= word_full[23:0];
        bcnt    <= bcnt + 1'b1;
        if (bcnt == 2'd3) begin
          if (word_full == TERM_WORD) begin
            done <= 1'b1;
          end else begin
            we    <= 1'b1;
            wdata <= word_full;
          end
        end
      end
    end
  end

  assign ready_o     = ready;
  assign we_o        = we;
  assign addr_o      = addr;
  assign wdata_o     = wdata;
  assign done_o      = done;
  assign frame_err_o = frame;
  assign core_rst_no = done;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Scoreboard bench for uart_prog_loader: a word-level loader model predicts
// memory writes; monitors compare every write strobe against the queue.
module tb_uart_prog_loader;

  logic clk = 1'b0;
  always #50 clk = ~clk;

  logic rst_n = 1'b0;
  logic rx0 = 1'b1, rx1 = 1'b1, en0 = 1'b0, en1 = 1'b0;

  logic        ready0, we0, done0, ferr0, crst0;
  logic [13:0] addr0;
  logic [31:0] wdata0;
  logic        ready1, we1, done1, ferr1, crst1;
  logic [1:0]  addr1;
  logic [31:0] wdata1;

  uart_prog_loader dut0 (
    .clk_i(clk), .rst_ni(rst_n), .rx_i(rx0), .en_i(en0),
    .ready_o(ready0), .we_o(we0), .addr_o(addr0), .wdata_o(wdata0),
    .done_o(done0), .frame_err_o(ferr0), .core_rst_no(crst0)
  );

  uart_prog_loader #(.CLKS_PER_BIT(16), .ADDR_W(2)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .rx_i(rx1), .en_i(en1),
    .ready_o(ready1), .we_o(we1), .addr_o(addr1), .wdata_o(wdata1),
    .done_o(done1), .frame_err_o(ferr1), .core_rst_no(crst1)
  );

  int tests = 0;
  int fails = 0;

  // Expected writes, {addr[15:0], data[31:0]}
  logic [47:0] sb0[$];
  logic [47:0] sb1[$];
  logic [47:0] e0, e1;

  // Loader reference model state per instance
  int          m_addr[2];
  int          m_cnt[2];
  int          m_wr[2];
  int          m_last[2];
  bit          m_done[2];
  logic [31:0] m_word[2];
  int          seen[2];

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void model_byte(int i, logic [7:0] b);
    if (m_done[i]) return;
    m_word[i] = (m_word[i] << 8) | 32'(b);
    m_cnt[i]++;
    if (m_cnt[i] == 4) begin
      m_cnt[i] = 0;
      if (m_word[i] == 32'h00000FFF) begin
        m_done[i] = 1'b1;
      end else begin
        if (i == 0) sb0.push_back({16'(m_addr[i]), m_word[i]});
        else        sb1.push_back({16'(m_addr[i]), m_word[i]});
        m_wr[i]++;
        if (m_addr[i] == m_last[i]) m_done[i] = 1'b1;
        else                        m_addr[i]++;
      end
    end
  endfunction

  // Write monitor for the full-size instance
  logic prev_we0 = 1'b0;
  always @(negedge clk) begin
    if (we0) begin
      check("we0_spacing", 64'(prev_we0), 64'd0);
      seen[0]++;
      if (sb0.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write0: addr 0x%0h data 0x%0h, no write expected", addr0, wdata0);
      end else begin
        e0 = sb0.pop_front();
        check("wr_addr0", 64'(addr0), 64'(e0[47:32]));
        check("wr_data0", 64'(wdata0), 64'(e0[31:0]));
      end
    end
    prev_we0 <= we0;
  end

  // Write monitor for the small-memory instance
  logic prev_we1 = 1'b0;
  always @(negedge clk) begin
    if (we1) begin
      check("we1_spacing", 64'(prev_we1), 64'd0);
      seen[1]++;
      if (sb1.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write1: addr 0x%0h data 0x%0h, no write expected", addr1, wdata1);
      end else begin
        e1 = sb1.pop_front();
        check("wr_addr1", 64'(addr1), 64'(e1[47:32]));
        check("wr_data1", 64'(wdata1), 64'(e1[31:0]));
      end
    end
    prev_we1 <= we1;
  end

  task automatic set_rx(int i, logic v);
    if (i == 0) rx0 = v;
    else        rx1 = v;
  endtask

  task automatic send_byte(int i, logic [7:0] b, bit stop_ok, int extra);
    int per = (i == 0) ? 87 : 16;
    set_rx(i, 1'b0);
    repeat (per + extra) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      set_rx(i, b[k]);
      repeat (per) @(negedge clk);
    end
    set_rx(i, stop_ok);
    repeat (per) @(negedge clk);
    if (!stop_ok) begin
      set_rx(i, 1'b1);
      repeat (per) @(negedge clk);
    end
    repeat ($urandom_range(2, 20)) @(negedge clk);
  endtask

  task automatic send_good(int i, logic [7:0] b, int extra);
    model_byte(i, b);
    send_byte(i, b, 1'b1, extra);
  endtask

  task automatic send_word(int i, logic [31:0] w);
    for (int k = 3; k >= 0; k--) send_good(i, w[8*k +: 8], 0);
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w = $urandom;
    if (w == 32'h00000FFF) w = 32'h12345678;
    return w;
  endfunction

  initial begin
    logic [31:0] w;
    for (int i = 0; i < 2; i++) begin
      m_addr[i] = 0; m_cnt[i] = 0; m_wr[i] = 0; m_done[i] = 1'b0;
      m_word[i] = '0; seen[i] = 0;
    end
    m_last[0] = 16383;
    m_last[1] = 3;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_we",    64'(we0),    64'd0);
    check("rst_addr",  64'(addr0),  64'd0);
    check("rst_wdata", 64'(wdata0), 64'd0);
    check("rst_done",  64'(done0),  64'd0);
    check("rst_ferr",  64'(ferr0),  64'd0);
    check("rst_crst",  64'(crst0),  64'd0);
    check("rst_ready", 64'(ready0), 64'd0);
    rst_n = 1'b1;
    en0 = 1'b1;
    en1 = 1'b1;
    repeat (3) @(negedge clk);
    check("ready_after_en", 64'(ready0), 64'd1);

    // Short low glitch on idle line must be rejected silently
    rx0 = 1'b0;
    repeat (20) @(negedge clk);
    rx0 = 1'b1;
    repeat (100) @(negedge clk);
    check("glitch_no_ferr", 64'(ferr0), 64'd0);

    // First word
    send_word(0, 32'hDEADBEEF);
    check("t1_writes", 64'(seen[0]), 64'(m_wr[0]));
    check("t1_done",   64'(done0),   64'd0);
    check("t1_ready",  64'(ready0),  64'd1);

    // Framing error: byte discarded, flag sticky
    send_byte(0, 8'h55, 1'b0, 0);
    check("ferr_set", 64'(ferr0), 64'd1);
    send_word(0, 32'h01020304);
    check("ferr_writes", 64'(seen[0]), 64'(m_wr[0]));

    // Start bit stretched by 10 clocks
    w = rand_word();
    send_good(0, 8'hA5, 10);
    for (int k = 2; k >= 0; k--) send_good(0, w[8*k +: 8], 0);
    check("stretch_writes", 64'(seen[0]), 64'(m_wr[0]));
    check("ferr_sticky",    64'(ferr0),   64'd1);

    // Enable drop after two bytes discards the partial word
    w = rand_word();
    send_good(0, w[31:24], 0);
    send_good(0, w[23:16], 0);
    en0 = 1'b0;
    repeat (4) @(negedge clk);
    m_cnt[0] = 0;
    check("en_low_ready", 64'(ready0), 64'd0);
    en0 = 1'b1;
    repeat (4) @(negedge clk);
    send_word(0, 32'h11223344);
    check("en_writes", 64'(seen[0]), 64'(m_wr[0]));

    // Three random words then the terminator
    for (int n = 0; n < 3; n++) send_word(0, rand_word());
    check("pre_term_done", 64'(done0), 64'd0);
    send_word(0, 32'h00000FFF);
    repeat (4) @(negedge clk);
    check("term_done",  64'(done0),  64'd1);
    check("term_crst",  64'(crst0),  64'd1);
    check("term_ready", 64'(ready0), 64'd0);
    check("term_writes", 64'(seen[0]), 64'(m_wr[0]));
    send_word(0, rand_word());
    check("post_done_writes", 64'(seen[0]), 64'(m_wr[0]));
    check("post_done_addr",   64'(addr0),   64'(m_addr[0]));

    // Small memory: fills after address 3, no wrap
    for (int n = 0; n < 3; n++) send_word(1, rand_word());
    check("small_not_done", 64'(done1), 64'd0);
    send_word(1, rand_word());
    repeat (4) @(negedge clk);
    check("small_done",   64'(done1),   64'(m_done[1]));
    check("small_crst",   64'(crst1),   64'd1);
    check("small_writes", 64'(seen[1]), 64'(m_wr[1]));
    check("small_addr",   64'(addr1),   64'(m_addr[1]));
    send_word(1, rand_word());
    check("small_post_writes", 64'(seen[1]), 64'(m_wr[1]));
    check("small_post_addr",   64'(addr1),   64'd3);

    repeat (20) @(negedge clk);
    check("sb0_drained", 64'(sb0.size()), 64'd0);
    check("sb1_drained", 64'(sb1.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
Synthesizable UART receiver and program loader for the instruction memory. It deserialises 8N1 bytes from the host serial line and assembles them MSB-first into 32-bit words. Each word is written to sequential instruction-memory addresses until a terminator word (0x00000FFF) arrives or memory is full. It sits between the chip's UART pad and the instruction-memory write port, and holds the core in reset until loading is complete.

Parameters:
CLKS_PER_BIT, 87, clock cycles per UART bit (10 MHz clk, 115200 baud)
ADDR_W, 14, word-address width (16384 words)
TERM_WORD, 32'h00000FFF, end-of-program marker; never written to memory

Ports:
clk_i  input  1  system clock
rst_ni  input  1  asynchronous active-low reset
rx_i  input  1  UART serial input, idle high, asynchronous to clk_i
en_i  input  1  loader enable; when low, FSMs held in IDLE and rx ignored
ready_o  output  1  high while loader is enabled and accepting bytes (not done)
we_o  output  1  one-cycle instruction-memory write strobe
addr_o  output  ADDR_W  word address for the write
wdata_o  output  32  word data for the write
done_o  output  1  sticky: program load complete
frame_err_o  output  1  sticky: a stop bit was sampled low
core_rst_no  output  1  active-low core reset; low until done_o

Behaviour:
- Reset (async, rst_ni=0): all outputs 0 except core_rst_no=0; rx synchroniser flops reset to 1; byte FSM=IDLE; byte counter=0; address=0.
- rx_i passes through a 2-flop synchroniser (reset value 1). All sampling uses the synchronised value rx_s.
- Byte FSM states: IDLE, START, DATA, STOP, plus a baud counter (0..CLKS_PER_BIT-1) and a bit index (0..7).
  - IDLE: when rx_s=0 and en_i=1 and done_o=0, go to START with the counter cleared.
  - START: at counter = CLKS_PER_BIT/2 (integer divide), resample. If rx_s=0, clear the counter and go to DATA. If rx_s=1, treat as a glitch and return to IDLE.
  - DATA: every CLKS_PER_BIT cycles, sample rx_s into shift[bit index] (LSB first). After bit 7, go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample. If rx_s=1, the byte is valid: pulse byte_valid for 1 cycle, then go to IDLE. If rx_s=0, set frame_err_o (sticky), discard the byte, and wait in STOP until rx_s=1 before returning to IDLE.
- Start-bit lengthening: a start bit longer than one bit period is tolerated. The START resample is the only start check, and DATA sampling is timed from the confirmed start midpoint.
- Word assembler:
  - On byte_valid: word <= {word[23:0], byte}; byte counter +1 (mod 4).
  - On the 4th byte, the complete word is compared against TERM_WORD in the same cycle.
  - Not a match: next cycle we_o=1, wdata_o=word, addr_o=current address; address increments after the strobe. Write latency is 1 cycle after the 4th stop-bit sample.
  - Match: no write; done_o=1 next cycle.
- Memory full: after the write to address 2^ADDR_W-1, done_o=1. The address does not wrap.
- done_o=1 ⇒ ready_o=0, core_rst_no=1, and further rx activity is ignored. Only rst_ni clears done_o.
- en_i deasserted mid-byte: byte FSM and byte counter return to IDLE/0 next cycle; address and sticky flags are preserved.
- ready_o = en_i & ~done_o (registered).
- we_o is never high in two consecutive cycles (minimum byte time ≫ 1 cycle).

Test Plan:
1. Reset, en_i=1, send bytes DE AD BE EF at 8681 ns/bit → one we_o pulse with addr_o=0 and wdata_o=0xDEADBEEF; done_o=0; ready_o=1.
2. Send 3 words, then 00 00 0F FF → 3 writes at addresses 0,1,2; done_o=1 with no 4th write; core_rst_no=1; ready_o=0. Further bytes cause no writes.
3. Byte 0x55 with its stop bit forced low → frame_err_o=1, no byte counted. The following 4 good bytes 01 02 03 04 → a single write of 0x01020304.
4. 20-cycle low glitch on idle rx_i → FSM returns to IDLE; no byte, no error.
5. Start bit stretched by 10 extra clocks (1000 ns), data 0xA5 → byte received as 0xA5 without error.
6. Deassert en_i after 2 bytes, reassert, then send 4 bytes 11 22 33 44 → write of 0x11223344 (partial bytes discarded). Separately: with ADDR_W=2, four writes → done_o=1 after addr 3.
